// File: rtl/pipe_trace_buffer_pkg.sv
// Shared types and helpers for the pipeline trace buffer.
//   pipe_trace_state_e : 2-bit capture state (IDLE/ARMED/TRIGGERED/DONE)
//   ST_*_ENC           : raw encodings as seen on the state port
//   oldest_ptr()       : (wr_ptr - count) mod depth, depth a power of two
package pipe_trace_pkg;

    localparam logic [1:0] ST_IDLE_ENC      = 2'd0;
    localparam logic [1:0] ST_ARMED_ENC     = 2'd1;
    localparam logic [1:0] ST_TRIGGERED_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = ST_IDLE_ENC,
        ST_ARMED     = ST_ARMED_ENC,
        ST_TRIGGERED = ST_TRIGGERED_ENC,
        ST_DONE      = ST_DONE_ENC
    } pipe_trace_state_e;

    // Unsigned wraparound of the subtraction is harmless because the mask
    // keeps only the low log2(depth) bits.
    function automatic int unsigned oldest_ptr(input int unsigned wr_ptr,
                                               input int unsigned count,
                                               input int unsigned depth);
        return (wr_ptr - count) & (depth - 1);
    endfunction

endpackage

// File: rtl/pipe_trace_buffer_trace_ram.sv
// Trace storage: DEPTH x W array, one synchronous write port and one
// asynchronous (combinational) read port. Storage is not reset.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, combinational from raddr_i
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 160
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_trace_buffer.sv
// Pipeline trace capture: snoops PC plus NUM_CH channel slices into a
// circular buffer, freezes POST_TRIG samples after a PC-match trigger and
// drains oldest-first over a valid/ready port.
// Optional macro PIPE_TRACE_TIMESTAMP_EN adds a per-entry cycle timestamp
// and the rd_ts output.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   sample_en           : capture qualifier
//   pc_in, ch_in        : snooped PC and packed channels (ch 0 in LSBs)
//   arm                 : pulse, restarts a capture
//   trig_en, trig_pc    : PC-match trigger
//   state               : 0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE
//   wrapped, count      : overflow flag, valid entry count
//   rd_valid/rd_ready   : readout handshake
//   rd_pc, rd_data      : entry at the read pointer
//   rd_ts               : entry timestamp (macro builds only)
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | no capture, no writes
// ARMED     | writing every sample, watching for trigger PC
// TRIGGERED | writing post-trigger samples, counting down
// DONE      | frozen, draining oldest-first
module pipe_trace_buffer
    import pipe_trace_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 32,
    parameter int PC_W      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    parameter int TS_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_en,
    input  logic [PC_W-1:0]            pc_in,
    input  logic [NUM_CH*CH_W-1:0]     ch_in,
    input  logic                       arm,
    input  logic                       trig_en,
    input  logic [PC_W-1:0]            trig_pc,
    output logic [1:0]                 state,
    output logic                       wrapped,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       rd_valid,
    input  logic                       rd_ready,
`ifdef PIPE_TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]            rd_ts,
`endif
    output logic [PC_W-1:0]            rd_pc,
    output logic [NUM_CH*CH_W-1:0]     rd_data
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int DATA_W = NUM_CH*CH_W;
`ifdef PIPE_TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = TS_W + PC_W + DATA_W;
`else
    localparam int ENTRY_W = PC_W + DATA_W;
`endif

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TS_W < 1)
        || (POST_TRIG < 0) || (POST_TRIG > DEPTH - 1)) begin : g_bad_params
        $error("pipe_trace_buffer: invalid DEPTH/POST_TRIG/TS_W");
    end

    pipe_trace_state_e  state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               wrapped_q, wrapped_d;
    logic [PTR_W-1:0]   post_q, post_d;
    logic               we;
    logic               trig_hit;
    logic               rd_valid_w;
    logic [ENTRY_W-1:0] wdata, rdata;

`ifdef PIPE_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]    ts_q, ts_d;
`endif

    assign trig_hit   = trig_en && sample_en && (pc_in == trig_pc);
    assign rd_valid_w = (state_q == ST_DONE) && (count_q != '0);

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        wrapped_d = wrapped_q;
        post_d    = post_q;
        we        = 1'b0;

        if (arm) begin
            // Arm overrides everything, including a same-cycle trigger.
            state_d   = ST_ARMED;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            wrapped_d = 1'b0;
            post_d    = '0;
        end else begin
            if (((state_q == ST_ARMED) || (state_q == ST_TRIGGERED)) && sample_en) begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (count_q == CNT_W'(DEPTH)) begin
                    wrapped_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            unique case (state_q)
                ST_IDLE: ;
                ST_ARMED: begin
                    if (trig_hit) begin
                        if (POST_TRIG == 0) begin
                            state_d  = ST_DONE;
                            rd_ptr_d = PTR_W'(oldest_ptr(32'(wr_ptr_d), 32'(count_d), DEPTH));
                        end else begin
                            state_d = ST_TRIGGERED;
                            post_d  = PTR_W'(POST_TRIG);
                        end
                    end
                end
                ST_TRIGGERED: begin
                    if (sample_en) begin
                        post_d = post_q - PTR_W'(1);
                        if (post_q == PTR_W'(1)) begin
                            state_d  = ST_DONE;
                            rd_ptr_d = PTR_W'(oldest_ptr(32'(wr_ptr_d), 32'(count_d), DEPTH));
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_valid_w && rd_ready) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        count_d  = count_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
            post_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            post_q    <= post_d;
        end
    end

`ifdef PIPE_TRACE_TIMESTAMP_EN
    // Each entry stores the post-increment counter value, so the first
    // sample after arm is stamped 1.
    always_comb begin
        ts_d = ts_q;
        if (arm) begin
            ts_d = '0;
        end else if ((state_q == ST_ARMED) || (state_q == ST_TRIGGERED)) begin
            ts_d = ts_q + TS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign wdata = {ts_d, pc_in, ch_in};
    assign rd_ts = rdata[ENTRY_W-1 -: TS_W];
`else
    assign wdata = {pc_in, ch_in};
`endif

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign state    = state_q;
    assign wrapped  = wrapped_q;
    assign count    = count_q;
    assign rd_valid = rd_valid_w;
    assign rd_pc    = rdata[DATA_W +: PC_W];
    assign rd_data  = rdata[DATA_W-1:0];

endmodule

// File: tb/tb_pipe_trace_buffer.sv
module tb_pipe_trace_buffer;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 32;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 16;
    localparam int POST   = 4;
    localparam int TS_W   = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   sample_en;
    logic [PC_W-1:0]        pc_in;
    logic [NUM_CH*CH_W-1:0] ch_in;
    logic                   arm;
    logic                   trig_en;
    logic [PC_W-1:0]        trig_pc;
    logic [1:0]             state;
    logic                   wrapped;
    logic [4:0]             count;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [PC_W-1:0]        rd_pc;
    logic [NUM_CH*CH_W-1:0] rd_data;
`ifdef PIPE_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]        rd_ts;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [PC_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    pipe_trace_buffer #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .PC_W(PC_W),
        .DEPTH(DEPTH), .POST_TRIG(POST), .TS_W(TS_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .pc_in     (pc_in),
        .ch_in     (ch_in),
        .arm       (arm),
        .trig_en   (trig_en),
        .trig_pc   (trig_pc),
        .state     (state),
        .wrapped   (wrapped),
        .count     (count),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
`ifdef PIPE_TRACE_TIMESTAMP_EN
        .rd_ts     (rd_ts),
`endif
        .rd_pc     (rd_pc),
        .rd_data   (rd_data)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted entry must match the queue head.
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL drain_extra: got pc %0h expected no entry", rd_pc);
            end else begin
                logic [PC_W-1:0] e;
                e = exp_q.pop_front();
                chk("drain_pc", 128'(rd_pc), 128'(e));
                chk("drain_data", 128'(rd_data), 128'({NUM_CH{e}}));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic feed(input logic [PC_W-1:0] pc);
        sample_en = 1'b1;
        pc_in     = pc;
        ch_in     = {NUM_CH{pc}};
        tick();
        sample_en = 1'b0;
    endtask

    initial begin
        int accepted;
        logic [3:0] rdy_pat;
        rdy_pat   = 4'b1001;
        rst_n     = 1'b0;
        sample_en = 1'b0;
        pc_in     = '0;
        ch_in     = '0;
        arm       = 1'b0;
        trig_en   = 1'b1;
        trig_pc   = 32'h0C;
        rd_ready  = 1'b0;
        #2;
        chk("por_state", 128'(state), 128'(0));
        chk("por_count", 128'(count), 128'(0));
        chk("por_rd_valid", 128'(rd_valid), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Reset mid-capture takes effect with no clock edge.
        trig_pc = 32'hFFFF_0000;
        do_arm();
        for (int n = 0; n < 18; n++) feed(32'h40 + 32'(4*n));
        chk("pre_rst_count", 128'(count), 128'(16));
        chk("pre_rst_wrapped", 128'(wrapped), 128'(1));
        rst_n = 1'b0;
        #2;
        chk("rst_state", 128'(state), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_wrapped", 128'(wrapped), 128'(0));
        chk("rst_rd_valid", 128'(rd_valid), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Basic capture: trigger at 0x0C, four post samples, done after 0x1C.
        trig_pc = 32'h0C;
        do_arm();
        chk("basic_armed", 128'(state), 128'(1));
        for (int n = 0; n < 7; n++) feed(32'(4*n));
        chk("basic_trig_state", 128'(state), 128'(2));
        feed(32'h1C);
        chk("basic_done_state", 128'(state), 128'(3));
        chk("basic_count", 128'(count), 128'(8));
        chk("basic_wrapped", 128'(wrapped), 128'(0));
        chk("basic_rd_valid", 128'(rd_valid), 128'(1));
`ifdef PIPE_TRACE_TIMESTAMP_EN
        chk("basic_first_ts", 128'(rd_ts), 128'(1));
`endif
        for (int n = 0; n < 8; n++) exp_q.push_back(32'(4*n));
        rd_ready = 1'b1;
        for (int i = 0; i < 40 && rd_valid; i++) tick();
        rd_ready = 1'b0;
        chk("basic_drained_valid", 128'(rd_valid), 128'(0));
        chk("basic_drained_state", 128'(state), 128'(3));
        chk("basic_queue_empty", 128'(exp_q.size()), 128'(0));

        // Wrap: 30 samples, trigger at n=25, keeps n=14..29.
        trig_pc = 32'h100 + 32'(4*25);
        do_arm();
        for (int n = 0; n < 30; n++) feed(32'h100 + 32'(4*n));
        chk("wrap_state", 128'(state), 128'(3));
        chk("wrap_wrapped", 128'(wrapped), 128'(1));
        chk("wrap_count", 128'(count), 128'(16));
        for (int n = 14; n < 30; n++) exp_q.push_back(32'h100 + 32'(4*n));

        // Backpressure drain with ready pattern 1,0,0,1.
        accepted = 0;
        for (int cyc = 0; cyc < 100 && accepted < 16; cyc++) begin
            rd_ready = rdy_pat[cyc % 4];
            #3;
            if (!rd_ready) begin
                chk("bp_hold_pc", 128'(rd_pc), 128'(32'h100 + 32'(4*(14+accepted))));
                chk("bp_hold_count", 128'(count), 128'(16 - accepted));
            end
            tick();
            if (rd_ready) accepted++;
        end
        rd_ready = 1'b0;
        chk("bp_accepts", 128'(accepted), 128'(16));
        chk("bp_count_end", 128'(count), 128'(0));
        chk("bp_valid_end", 128'(rd_valid), 128'(0));
        chk("bp_queue_empty", 128'(exp_q.size()), 128'(0));

        // Arm with a matching PC in the same cycle: no trigger, no write.
        trig_pc   = 32'h240;
        sample_en = 1'b1;
        pc_in     = 32'h240;
        ch_in     = {NUM_CH{32'h240}};
        do_arm();
        sample_en = 1'b0;
        chk("arm_match_state", 128'(state), 128'(1));
        chk("arm_match_count", 128'(count), 128'(0));
        // Match without sample_en is ignored.
        tick();
        chk("nosample_state", 128'(state), 128'(1));
        chk("nosample_count", 128'(count), 128'(0));
        feed(32'h200);
        chk("edge_count1", 128'(count), 128'(1));
        feed(32'h240);
        chk("edge_trig", 128'(state), 128'(2));
        for (int n = 1; n <= 4; n++) feed(32'h240 + 32'(4*n));
        chk("edge_done", 128'(state), 128'(3));
        chk("edge_count", 128'(count), 128'(6));

        // Arm during drain aborts readout.
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h240);
        rd_ready = 1'b1;
        tick();
        tick();
        rd_ready = 1'b0;
        chk("mid_drain_count", 128'(count), 128'(4));
        do_arm();
        chk("abort_count", 128'(count), 128'(0));
        chk("abort_state", 128'(state), 128'(1));
        chk("abort_valid", 128'(rd_valid), 128'(0));
        chk("abort_queue_empty", 128'(exp_q.size()), 128'(0));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
- Synthesizable, parametrised pipeline trace capture block for the CPU; the on-chip successor to watching pipeline registers from a bench.
- Snoops currentPC plus NUM_CH pipeline-register slices (IF_ID, ID_EXE, EXE_MEM, MEM_WB style) each sampled cycle into a circular buffer.
- Freezes the buffer on a PC-match trigger after a programmable post-trigger window, then drains oldest-first over a valid/ready port.

Parameters:
- NUM_CH, 4, number of snooped pipeline channels
- CH_W, 32, bits captured per channel (callers slice wider pipeline registers)
- PC_W, 32, PC width
- DEPTH, 16, buffer entries; power of two, >=2
- POST_TRIG, 4, samples stored after the trigger sample; 0..DEPTH-1
- TS_W, 16, timestamp width (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- sample_en  in  1  qualifies a capture cycle (tie high for every cycle)
- pc_in  in  PC_W  current PC
- ch_in  in  NUM_CH*CH_W  packed channel data, channel 0 in LSBs
- arm  in  1  single-cycle pulse; starts a new capture
- trig_en  in  1  enables PC-match trigger
- trig_pc  in  PC_W  trigger PC
- state  out  2  0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE
- wrapped  out  1  pre-trigger writes overflowed DEPTH
- count  out  $clog2(DEPTH+1)  valid entries, saturating at DEPTH
- rd_valid  out  1  entry available in DONE
- rd_ready  in  1  consumer accepts entry
- rd_pc  out  PC_W  entry PC
- rd_data  out  NUM_CH*CH_W  entry channel data

Behaviour:
- Reset (async, rst_n low): state=IDLE, wr_ptr=0, rd_ptr=0, count=0, wrapped=0, rd_valid=0, post counter=0. rd_pc/rd_data are don't-care while rd_valid=0. Storage array is not reset.
- IDLE: no writes. arm -> ARMED next cycle, with wr_ptr=0, count=0, wrapped=0.
- ARMED: each sample_en cycle writes {pc_in, ch_in} at wr_ptr.
  - wr_ptr increments modulo DEPTH.
  - count increments, saturating at DEPTH; a write at count==DEPTH sets wrapped=1.
  - If trig_en && pc_in==trig_pc && sample_en: the sample is written and the state moves to TRIGGERED with post counter=POST_TRIG. If POST_TRIG==0, go directly to DONE.
  - A match without sample_en is ignored.
- TRIGGERED: sample_en writes continue and decrement the post counter. The write that brings the counter to 0 moves the state to DONE. Further trigger matches are ignored.
- DONE: writes stop.
  - On entry, rd_ptr = (wr_ptr - count) mod DEPTH, so the oldest entry is presented first.
  - rd_valid = (count != 0). rd_pc/rd_data are read combinationally at rd_ptr.
  - On rd_valid && rd_ready: rd_ptr++ (mod DEPTH) and count--.
  - Outputs must hold stable while rd_valid && !rd_ready.
  - At count==0: rd_valid=0 and the block stays in DONE until arm.
- arm in any state restarts the capture as in IDLE: any readout is aborted, and no sample is written in the arm cycle.
- arm and trigger in the same cycle: arm wins, the trigger is ignored.
- Total stored entries = min(pre-trigger samples + 1 + POST_TRIG, DEPTH). Oldest entries are overwritten on wrap.
- State encoding changes only on clock edges or reset. Latency from the trigger sample to rd_valid is POST_TRIG sample cycles + 1 clk.

Optional Feature:
- Macro: PIPE_TRACE_TIMESTAMP_EN.
- Defined:
  - Adds a TS_W free-running cycle counter, cleared to 0 on arm and on reset, incrementing every clk while ARMED/TRIGGERED (wraps).
  - Each written entry stores the counter value.
  - Adds port rd_ts out TS_W, aligned with rd_pc.
- Undefined: no counter, no rd_ts port, no timestamp storage.

Decomposition:
- pipe_trace_pkg holds:
  - the state typedef (IDLE/ARMED/TRIGGERED/DONE, 2-bit)
  - state encoding constants
  - a helper function for the pointer-minus-count modulo calculation
- One sub-module, trace_ram:
  - DEPTH x (PC_W+NUM_CH*CH_W[+TS_W]) storage
  - one synchronous write port, one asynchronous read port
  - no reset on storage

Test Plan (DEPTH=16, POST_TRIG=4, NUM_CH=4, CH_W=32, trig_en=1):
- Reset check: assert rst_n=0 mid-capture -> state=0, count=0, rd_valid=0, wrapped=0 immediately (no clk edge required).
- Basic capture: arm, feed PC 0x00,0x04,... with ch_in=PC replicated, trig_pc=0x0C -> DONE after PC 0x1C. count=8, wrapped=0. Drain yields PCs 0x00..0x1C in order.
- Wrap: arm, feed 30 samples of PC 0x100+4n, trig_pc=0x100+4*25 -> wrapped=1, count=16. Drain yields n=14..29 oldest first.
- Backpressure: in DONE, toggle rd_ready 1,0,0,1 -> rd_pc holds during the 0 cycles. count decrements only on handshakes. rd_valid drops after the 16th accept.
- Edge cases:
  - arm and a matching PC in the same cycle -> no trigger, state=ARMED.
  - Match with sample_en=0 -> ignored.
  - arm during drain -> count=0, state=ARMED next cycle.
- With PIPE_TRACE_TIMESTAMP_EN: continuous sample_en from arm -> rd_ts increases by exactly 1 per drained entry. First rd_ts = 1 for the non-wrapped capture.
